// File: rtl/div_unit_pkg.sv
// Shared state encoding and handshake constants for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration: subtract the divisor from the shifted
// partial remainder and keep the difference only when it did not go negative.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   rem_o,
  output logic              q_bit_o
);

  logic signed [DATA_W+1:0] trial;

  // One extra bit above the working window holds the borrow/sign of the trial.
  assign trial   = $signed({1'b0, rem_i}) - $signed({2'b00, divisor_i});
  assign q_bit_o = ~trial[DATA_W+1];
  assign rem_o   = q_bit_o ? trial[DATA_W:0] : rem_i;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX; stalls EX while busy and holds
// {remainder, quotient} until the EX stage advances.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int STALL_W      = 6,
  parameter int EX_STALL_BIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  div_start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     dividend,
  input  logic [DATA_W-1:0]     divisor,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_for_ex
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WORK_W = 2*DATA_W + 1;

  div_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WORK_W-1:0]         work_q, work_d;
  logic [DATA_W-1:0]         divisor_q, divisor_d;
  logic                      q_neg_q, q_neg_d;
  logic                      r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0]       result_q, result_d;
  logic                      ready_q, ready_d;

  logic [WORK_W-1:0]         shifted;
  logic [WORK_W-1:0]         work_step;
  logic [DATA_W:0]           step_rem;
  logic                      step_qbit;
  logic                      unused_bits;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic en);
    return (en && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  // The working register's top bit is always zero after a restoring step,
  // and only one stall bit is relevant here.
  assign unused_bits = ^{work_q[WORK_W-1], stall};

  assign shifted = {work_q[WORK_W-2:0], 1'b0};

  div_unit_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem_i    (shifted[WORK_W-1:DATA_W]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_qbit)
  );

  assign work_step = {step_rem, shifted[DATA_W-1:1], step_qbit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    if (annul) begin
      state_d = DIV_FREE;
      ready_d = DIV_RESULT_NOT_READY;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          if (div_start != DIV_STOP) begin
            if (divisor == '0) begin
              state_d = DIV_BY_ZERO;
            end else begin
              divisor_d = abs_val(divisor, signed_div);
              work_d    = {{(DATA_W+1){1'b0}}, abs_val(dividend, signed_div)};
              q_neg_d   = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
              r_neg_d   = signed_div & dividend[DATA_W-1];
              cnt_d     = '0;
              state_d   = DIV_ON;
            end
          end
        end
        DIV_BY_ZERO: begin
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
        DIV_ON: begin
          work_d = work_step;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            result_d = {fix_sign(work_step[2*DATA_W-1:DATA_W], r_neg_q),
                        fix_sign(work_step[DATA_W-1:0], q_neg_q)};
            ready_d  = DIV_RESULT_READY;
            state_d  = DIV_END;
          end
        end
        DIV_END: begin
          // Stay here while EX is frozen so the same divide is not restarted.
          if (!stall[EX_STALL_BIT]) begin
            ready_d = DIV_RESULT_NOT_READY;
            state_d = DIV_FREE;
          end
        end
        default: state_d = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q    <= work_d;
    divisor_q <= divisor_d;
    q_neg_q   <= q_neg_d;
    r_neg_q   <= r_neg_d;
  end

  assign result          = result_q;
  assign ready           = ready_q;
  assign stallreq_for_ex = div_start & ~ready_q & ~annul;

endmodule
